// File: rtl/neander_io_port.sv
// rtl/neander_io_port.sv - NEANDER-X OUT/IN port responder with TX and RX byte FIFOs
module neander_io_port #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_write,
    input  logic [7:0] io_wdata,
    input  logic       io_data_rd,
    input  logic       io_stat_rd,
    output logic [7:0] io_in,
    output logic [7:0] io_status,
    output logic [7:0] ext_tx_data,
    output logic       ext_tx_valid,
    input  logic       ext_tx_ready,
    input  logic [7:0] ext_rx_data,
    input  logic       ext_rx_valid,
    output logic       ext_rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_STEP   = CW'(1);
    localparam logic [AW-1:0] PTR_STEP   = AW'(1);

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [CW-1:0] tx_count;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [CW-1:0] rx_count;
    logic          rx_ovf, tx_ovf;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_ovf_event, rx_ovf_event;

    // Full/empty come from registered counts only, so a same-cycle pop never frees room for a push.
    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);

    assign tx_push      = io_write && !tx_full;
    assign tx_pop       = ext_tx_ready && !tx_empty;
    assign rx_push      = ext_rx_valid && !rx_full;
    assign rx_pop       = io_data_rd && !rx_empty;
    assign tx_ovf_event = io_write && tx_full;
    assign rx_ovf_event = ext_rx_valid && rx_full;

    assign ext_tx_valid = !tx_empty;
    assign ext_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];
    assign ext_rx_ready = !rx_full;
    assign io_in        = rx_empty ? 8'h00 : rx_mem[rx_rptr];
    assign io_status    = {3'b000, tx_ovf, rx_ovf, tx_empty, tx_full, !rx_empty};

    // TX storage: written only on an accepted push; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= io_wdata;
        end
    end

    // TX pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + PTR_STEP;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + PTR_STEP;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_STEP;
                2'b01:   tx_count <= tx_count - CNT_STEP;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // RX storage: written only on a completed source handshake.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= ext_rx_data;
        end
    end

    // RX pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + PTR_STEP;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + PTR_STEP;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_STEP;
                2'b01:   rx_count <= rx_count - CNT_STEP;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Sticky overflow flags: a status read clears them, but a coincident overflow keeps them set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (rx_ovf_event) begin
                rx_ovf <= 1'b1;
            end else if (io_stat_rd) begin
                rx_ovf <= 1'b0;
            end
            if (tx_ovf_event) begin
                tx_ovf <= 1'b1;
            end else if (io_stat_rd) begin
                tx_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/neander_io_port.md
# neander_io_port

I/O responder for the NEANDER-X CPU. It sits on the far side of the CPU's OUT/IN port. On the output path it captures each byte the CPU writes and buffers it in a TX FIFO. The FIFO drains to an external sink over a valid/ready handshake. On the input path it accepts bytes from an external source into an RX FIFO and presents them to the CPU as IN data (address 0) and IN status (address 1).

## Interface

- DEPTH, 4, entries per FIFO; power of two, minimum 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears pointers, counts and sticky flags.
- io_write  in  1  one-cycle strobe from the CPU OUT instruction; pushes io_wdata into TX.
- io_wdata  in  8  CPU accumulator value for OUT.
- io_data_rd  in  1  one-cycle strobe from the CPU IN instruction, address 0; pops the RX head.
- io_stat_rd  in  1  one-cycle strobe from the CPU IN instruction, address 1; clears sticky bits.
- io_in  out  8  RX head byte; 0x00 when RX is empty.
- io_status  out  8  status byte:
  - bit0 RX_AVAIL, set when the RX count is greater than 0.
  - bit1 TX_FULL.
  - bit2 TX_EMPTY.
  - bit3 RX_OVF, sticky.
  - bit4 TX_OVF, sticky.
  - bits 7:5 read as 0.
- ext_tx_data  out  8  TX head byte; 0x00 when TX is empty.
- ext_tx_valid  out  1  TX is not empty.
- ext_tx_ready  in  1  the sink accepts the head byte when valid and ready are both high at a rising edge.
- ext_rx_data  in  8  byte offered by the external source.
- ext_rx_valid  in  1  the source has a byte on ext_rx_data.
- ext_rx_ready  out  1  RX is not full.

## Operation

- Each FIFO has:
  - a register-array memory of DEPTH bytes;
  - read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH;
  - a count of log2(DEPTH)+1 bits.
- TX push:
  - io_write while TX is not full writes io_wdata at the write pointer, then increments the pointer and the count.
  - io_write while TX is full drops the byte, sets TX_OVF, and leaves the FIFO unchanged.
  - The full decision uses the registered count. A pop in the same cycle does not make room for that cycle's push.
- TX pop: when ext_tx_valid and ext_tx_ready are both high, the read pointer increments and the count decrements.
- TX push and pop in the same cycle, with TX neither empty nor full: both take effect and the count is unchanged.
- RX push:
  - When ext_rx_valid and ext_rx_ready are both high, ext_rx_data is stored.
  - ext_rx_valid while RX is full has no handshake, so the byte is not taken and RX_OVF is set. The source must hold the byte; RX_OVF is diagnostic only.
- RX pop:
  - io_data_rd while RX is not empty advances the read pointer.
  - io_data_rd while RX is empty has no effect and sets no flag.
- RX push and pop in the same cycle: both take effect.
- Sticky flags:
  - io_stat_rd clears RX_OVF and TX_OVF at the next edge.
  - If an overflow event occurs in the same cycle as io_stat_rd, setting wins and the flag stays 1.
  - io_status during the io_stat_rd cycle still shows the pre-clear value, so the CPU reads the flags before they clear.
- io_data_rd and io_stat_rd asserted together: each performs its own action independently.

## Timing

- All outputs are decoded combinationally from registered state only. There is no input-to-output combinational path.
- Reset values:
  - io_in 0x00.
  - io_status 0x04 (TX_EMPTY).
  - ext_tx_data 0x00.
  - ext_tx_valid 0.
  - ext_rx_ready 1.
- Reset asserted mid-transfer discards all FIFO contents. No handshake completes in the reset cycle.
- Latency:
  - After an io_write at edge N, ext_tx_valid and ext_tx_data are valid after edge N.
  - After an RX handshake at edge N, RX_AVAIL and io_in are valid after edge N.
  - The CPU samples io_in in the same cycle it asserts io_data_rd. The pop shows on io_in after that edge.
- Throughput: one push and one pop per FIFO per cycle.
- ext_tx_data is stable while ext_tx_valid is high and no pop occurs.

## Test plan

- Reset, then idle:
  - io_status=0x04, io_in=0x00, ext_tx_valid=0, ext_rx_ready=1.
- Write 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles with ext_tx_ready=0, then io_stat_rd:
  - After 4 writes, TX_FULL=1 and TX_EMPTY=0.
  - The 5th write sets TX_OVF, so io_status=0x12.
  - After io_stat_rd, io_status=0x02.
  - With ext_tx_ready=1, the sink receives 0x11, 0x22, 0x33, 0x44 in order on 4 consecutive cycles; then io_status=0x04.
- Source offers 0xA0..0xA4 with ext_rx_valid held high:
  - ext_rx_ready drops after 4 bytes; RX_OVF=1 (io_status=0x0D).
  - io_data_rd reads 0xA0, 0xA1, 0xA2, 0xA3 in order.
  - 0xA4 enters RX once space frees.
- Pointer wrap: 10 push/pop pairs through each FIFO with DEPTH=4 and data 0x00..0x09:
  - Order is preserved across the pointer wrap.
  - The count never exceeds 4.
- Simultaneous events:
  - RX holding 2 bytes, RX push and io_data_rd in one cycle: count stays 2.
  - TX full, pop and io_write in one cycle: the write is dropped and TX_OVF is set.
  - io_stat_rd in the same cycle as an overflow: the flag stays 1.
- Reset mid-stream with 3 bytes in TX and 2 in RX:
  - All outputs return to their reset values.
  - A write after reset emits only the new byte.
